// File: rtl/bit_serializer_if.sv
// Parallel-in / serial-out handshake bundle for bit_serializer.
// master drives words and ser_en; slave (the serializer) drives the serial side.
interface bit_serializer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LEN_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LEN_W-1:0] in_len;
    logic             ser_en;
    logic             ser_bit;
    logic             ser_valid;
    logic             ser_last;

    modport master (
        output in_valid, in_data, in_len, ser_en,
        input  in_ready, ser_bit, ser_valid, ser_last
    );

    modport slave (
        input  in_valid, in_data, in_len, ser_en,
        output in_ready, ser_bit, ser_valid, ser_last
    );
endinterface

// File: rtl/bit_serializer.sv
// LSB-first word serializer with a one-word hold buffer for bubble-free streaming.
// Optional macro SER_PARITY_EN appends an even-parity bit after each word.
module bit_serializer #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned LEN_W    = 5,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    bit_serializer_if.slave     bus,
    output logic                busy,
    output logic [15:0]         word_count
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] act_q, act_n, hold_q, hold_n;
    logic [LEN_W-1:0] len_q, len_n, hlen_q, hlen_n, cnt_q, cnt_n;
    logic [LEN_W-1:0] len_cl;
    logic             hold_full_q, hold_full_n;
    logic [15:0]      wc_n;
    logic             ser_bit_n, ser_valid_n, ser_last_n, in_ready_n, busy_n;
    logic             accept;
`ifdef SER_PARITY_EN
    logic             par_q, par_n;
`endif

    assign accept = bus.in_valid & bus.in_ready;

    // Out-of-range lengths (0 or above WIDTH) mean a full word
    always_comb begin
        len_cl = bus.in_len;
        if (bus.in_len == '0 || bus.in_len > LEN_W'(WIDTH))
            len_cl = LEN_W'(WIDTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            act_q         <= '0;
            hold_q        <= '0;
            len_q         <= '0;
            hlen_q        <= '0;
            cnt_q         <= '0;
            hold_full_q   <= 1'b0;
            word_count    <= '0;
            bus.in_ready  <= 1'b1;
            bus.ser_bit   <= IDLE_BIT;
            bus.ser_valid <= 1'b0;
            bus.ser_last  <= 1'b0;
            busy          <= 1'b0;
`ifdef SER_PARITY_EN
            par_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_n;
            act_q         <= act_n;
            hold_q        <= hold_n;
            len_q         <= len_n;
            hlen_q        <= hlen_n;
            cnt_q         <= cnt_n;
            hold_full_q   <= hold_full_n;
            word_count    <= wc_n;
            bus.in_ready  <= in_ready_n;
            bus.ser_bit   <= ser_bit_n;
            bus.ser_valid <= ser_valid_n;
            bus.ser_last  <= ser_last_n;
            busy          <= busy_n;
`ifdef SER_PARITY_EN
            par_q         <= par_n;
`endif
        end
    end

    // Next state plus next values of every registered output
    always_comb begin
        state_n     = state_q;
        act_n       = act_q;
        hold_n      = hold_q;
        len_n       = len_q;
        hlen_n      = hlen_q;
        cnt_n       = cnt_q;
        hold_full_n = hold_full_q;
        wc_n        = word_count;
`ifdef SER_PARITY_EN
        par_n       = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    act_n   = bus.in_data;
                    len_n   = len_cl;
                    cnt_n   = '0;
`ifdef SER_PARITY_EN
                    par_n   = 1'b0;
`endif
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.ser_en && bus.ser_last) begin
                    wc_n = word_count + 16'd1;
                    if (hold_full_q) begin
                        act_n       = hold_q;
                        len_n       = hlen_q;
                        cnt_n       = '0;
                        hold_full_n = 1'b0;
`ifdef SER_PARITY_EN
                        par_n       = 1'b0;
`endif
                    end else if (accept) begin
                        act_n = bus.in_data;
                        len_n = len_cl;
                        cnt_n = '0;
`ifdef SER_PARITY_EN
                        par_n = 1'b0;
`endif
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    if (bus.ser_en) begin
                        act_n = act_q >> 1;
                        cnt_n = cnt_q + LEN_W'(1);
`ifdef SER_PARITY_EN
                        par_n = par_q ^ act_q[0];
`endif
                    end
                    if (accept) begin
                        hold_n      = bus.in_data;
                        hlen_n      = len_cl;
                        hold_full_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        ser_valid_n = (state_n == SHIFT);
        ser_bit_n   = IDLE_BIT;
        ser_last_n  = 1'b0;
        if (state_n == SHIFT) begin
            ser_bit_n  = act_n[0];
`ifdef SER_PARITY_EN
            if (cnt_n == len_n)
                ser_bit_n = par_n;
            ser_last_n = (cnt_n == len_n);
`else
            ser_last_n = (cnt_n == len_n - LEN_W'(1));
`endif
        end
        in_ready_n = ~hold_full_n;
        busy_n     = ser_valid_n | hold_full_n;
    end

endmodule
